// File: rtl/ex_div.sv
// ex_div -- multi-cycle radix-2 restoring integer divider for the EX stage.
// Executes DIV/DIVU/REM/REMU and holds the pipeline through stallreq while
// an operation is in flight.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          divide request, held high until result_ready is seen
//   annul          cancel the current operation (flush / exception)
//   signed_div     1 = signed DIV/REM, 0 = unsigned DIVU/REMU
//   dividend       operand A, sampled in IDLE on acceptance
//   divisor        operand B, sampled in IDLE on acceptance
//   quotient       registered quotient
//   remainder      registered remainder
//   result_ready   registered, quotient/remainder valid
//   stallreq       combinational stall request to the stall controller
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             annul,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_ready,
    output logic             stallreq
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_reg;    // dividend magnitude, shifts into quotient
    logic [WIDTH-1:0] b_reg;    // divisor magnitude
    logic [WIDTH-1:0] prem;     // partial remainder
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             last_step;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] prem_next;
    logic [WIDTH-1:0] a_next;

    assign stallreq  = start & ~result_ready & ~annul;
    assign accept    = start & ~annul;
    assign last_step = (count == CW'(WIDTH - 1));

    // Magnitudes only matter for signed ops; unsigned operands pass through raw.
    assign dividend_abs = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_abs  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract on
    // WIDTH+1 bits so the borrow shows up in the top bit.
    assign rem_sh    = {prem, a_reg[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, b_reg};
    assign q_bit     = ~diff[WIDTH];
    assign prem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign a_next    = {a_reg[WIDTH-2:0], q_bit};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (divisor == '0) ? BYZERO : RUN;
            end
            BYZERO: begin
                state_next = annul ? IDLE : DONE;
            end
            RUN: begin
                if (annul)          state_next = IDLE;
                else if (last_step) state_next = DONE;
            end
            DONE: begin
                if (annul || !start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            prem         <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            result_ready <= 1'b0;
        end else begin
            state        <= state_next;
            result_ready <= (state_next == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Divide-by-zero returns the raw dividend as remainder,
                        // so keep it unmodified in that case.
                        a_reg <= (divisor == '0) ? dividend : dividend_abs;
                        b_reg <= divisor_abs;
                        q_neg <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg <= signed_div & dividend[WIDTH-1];
                        prem  <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (!annul) begin
                        a_reg <= a_next;
                        prem  <= prem_next;
                        count <= count + 1'b1;
                        if (last_step) begin
                            quotient  <= q_neg ? -a_next : a_next;
                            remainder <= r_neg ? -prem_next : prem_next;
                        end
                    end
                end
                BYZERO: begin
                    if (!annul) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        annul;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        result_ready;
    logic        stallreq;

    int tests = 0;
    int fails = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .annul(annul),
        .signed_div(signed_div), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder),
        .result_ready(result_ready), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation with start held, count edges to result_ready,
    // scramble operands after acceptance, then release start.
    task automatic run_op(input string name, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input int elat);
        int lat;
        int stall_bad;
        @(negedge clk);
        signed_div = sd; dividend = a; divisor = b; start = 1'b1;
        #1;
        check({name, " stallreq_first"}, 32'(stallreq), 32'd1);
        lat = 0;
        stall_bad = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                dividend = $urandom; divisor = $urandom; signed_div = ~sd;
            end
            if (result_ready) break;
            if (stallreq !== 1'b1) stall_bad++;
        end
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " stall_held"}, 32'(stall_bad), 32'd0);
        check({name, " stall_drop"}, 32'(stallreq), 32'd0);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " ready_clear"}, 32'(result_ready), 32'd0);
        check({name, " q_hold"}, quotient, eq);
    endtask

    initial begin
        vecs[0] = '{"u100/7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1] = '{"s-7/2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2] = '{"s7/-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3] = '{"u-7/2",    1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33};
        vecs[4] = '{"s5/0",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
        vecs[5] = '{"u5/0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
        vecs[6] = '{"s-5/0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  2};
        vecs[7] = '{"s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[8] = '{"u_max/1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[9] = '{"s-100/-7", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        dividend = '0; divisor = '0;
        #1;
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        check("rst ready", 32'(result_ready), 32'd0);
        check("rst stallreq", 32'(stallreq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].name, vecs[i].sd, vecs[i].a, vecs[i].b,
                   vecs[i].q, vecs[i].r, vecs[i].lat);

        // Annul mid-RUN: no result, outputs keep the previous operation's values.
        @(negedge clk);
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1;
        check("annul stallreq", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        check("annul ready", 32'(result_ready), 32'd0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("annul ready_late", 32'(result_ready), 32'd0);
        check("annul q_hold", quotient, 32'd14);
        check("annul r_hold", remainder, 32'hFFFF_FFFE);
        run_op("u50/3", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 33);

        // Asynchronous reset between edges in the middle of RUN.
        @(negedge clk);
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd7; start = 1'b1;
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b1; start = 1'b0;
        #1;
        check("mid_rst quotient", quotient, 32'd0);
        check("mid_rst remainder", remainder, 32'd0);
        check("mid_rst ready", 32'(result_ready), 32'd0);
        check("mid_rst stallreq", 32'(stallreq), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle radix-2 restoring integer divider in the EX stage; executes DIV/DIVU/REM/REMU.
- Acts as the requesting side of the pipeline stall interface.
- Drives stallreq, wired to the stall controller's EX stall-request input, while an operation is in flight.
- Freezes upstream stages until quotient/remainder are ready; EX writeback logic consumes the result when result_ready is high.

Parameters:
WIDTH, 32, operand/result width in bits (one iteration per bit)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  divide request from EX; held high until result_ready is seen
annul  input  1  cancel current operation (branch flush / exception)
signed_div  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with start in IDLE
dividend  input  WIDTH  operand A; sampled in IDLE when accepted
divisor  input  WIDTH  operand B; sampled in IDLE when accepted
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
result_ready  output  1  registered; quotient/remainder valid
stallreq  output  1  combinational stall request to stall controller

Behaviour:
- Reset (async, any state): state=IDLE, quotient=0, remainder=0, result_ready=0, count=0, internal operand/sign registers=0.
- stallreq = start & ~result_ready & ~annul (combinational; high from the first cycle start is seen).
- States: IDLE, BYZERO, RUN, DONE.
- IDLE:
  - start=1 & annul=0 & divisor==0 -> BYZERO; latch dividend.
  - start=1 & annul=0 & divisor!=0 -> RUN.
  - On entry to RUN, latch |dividend| and |divisor| (absolute values only when signed_div=1, else raw).
  - Latch q_neg = signed_div & (dividend[MSB]^divisor[MSB]) and r_neg = signed_div & dividend[MSB].
  - Clear partial remainder; count=0.
- RUN: one restoring step per cycle:
  - Shift {partial_rem, quotient_shift} left by 1.
  - Trial-subtract divisor on WIDTH+1 bits; if non-negative, keep the difference and set quotient LSB=1.
  - count increments; after step WIDTH-1 (count==WIDTH-1) -> DONE.
  - On that transition: quotient = q_neg ? -q : q; remainder = r_neg ? -r : r (two's complement, WIDTH bits).
- BYZERO: 1 cycle -> DONE with quotient = all ones, remainder = latched dividend (signed and unsigned alike).
- DONE:
  - result_ready=1; quotient/remainder held stable.
  - Stays while start=1.
  - start=0 -> IDLE; result_ready clears on that edge, while quotient/remainder keep their last values.
- annul=1 in BYZERO, RUN or DONE -> IDLE next edge; result_ready=0; no result is produced.
- annul=1 in IDLE blocks acceptance.
- Latency: start accepted at edge 0 -> result_ready high after edge WIDTH+1 (33 cycles for WIDTH=32). Divide-by-zero: after edge 2.
- Overflow (signed, dividend = -2^(WIDTH-1), divisor = -1): no special path. Magnitude 2^(WIDTH-1) fits the unsigned datapath, giving quotient = 0x80000000 and remainder = 0.
- Operand inputs are ignored outside IDLE; changes during RUN do not affect the result.
- Back-to-back: a new operation requires start to drop for at least one cycle (DONE -> IDLE), then rise again.

Test Plan:
- Unsigned 100/7, start held -> stallreq=1 for 33 cycles; result_ready at cycle 33 with quotient=14, remainder=2; stallreq drops the same cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed 7/-2 -> quotient=-3, remainder=1.
- Divide by zero, dividend=5, signed and unsigned -> result_ready after 2 cycles, quotient=0xFFFFFFFF, remainder=5.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- annul asserted at RUN cycle 10 -> IDLE next edge, result_ready=0, stallreq=0. A fresh 50/3 then completes in 33 cycles with quotient=16, remainder=2.
- rst pulsed mid-RUN (cycle 20, asynchronous between edges) -> all outputs 0 immediately. After release, 9/3 yields quotient=3, remainder=0.
